// File: rtl/freelist_checkpoint_ctrl.sv
// rtl/freelist_checkpoint_ctrl.sv - branch checkpoint manager for the speculative free list
// Snapshots the free-list head per control instruction and restores it on mispredict.
module freelist_checkpoint_ctrl #(
  parameter int N_CP     = 4,
  parameter int N_CP_LOG = 2,
  parameter int FL_LOG   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                recoverFlag_i,
  input  logic                cpAlloc_i,
  input  logic [FL_LOG-1:0]   freeListHead_i,
  output logic [N_CP_LOG-1:0] cpId_o,
  output logic                cpFull_o,
  input  logic                ctrlValid_i,
  input  logic [N_CP_LOG-1:0] ctrlCpId_i,
  input  logic                ctrlMispredict_i,
  output logic                ctrlVerified_o,
  output logic                flagRecoverEX_o,
  output logic [FL_LOG-1:0]   freeListHeadCp_o,
  output logic [N_CP_LOG:0]   cpCount_o
);

  localparam logic [N_CP_LOG:0] CP_MAX = (N_CP_LOG+1)'(N_CP);

  logic [FL_LOG-1:0]   head [N_CP];
  logic [N_CP-1:0]     valid, done;
  logic [N_CP-1:0]     valid_n, done_n, squash;
  logic [N_CP_LOG-1:0] alloc_ptr, retire_ptr, retire_next;
  logic [N_CP_LOG-1:0] ctrl_age, age;
  logic [N_CP_LOG:0]   count;
  logic                verified_q, recover_q;
  logic [FL_LOG-1:0]   head_cp_q;

  logic resolve_hit, mispredict, correct, alloc_fire, retire_fire;

  assign cpId_o           = alloc_ptr;
  assign cpFull_o         = (count == CP_MAX);
  assign cpCount_o        = count;
  assign ctrlVerified_o   = verified_q;
  assign flagRecoverEX_o  = recover_q;
  assign freeListHeadCp_o = head_cp_q;

  assign resolve_hit = ctrlValid_i && valid[ctrlCpId_i];
  assign mispredict  = resolve_hit && ctrlMispredict_i;
  assign correct     = resolve_hit && !ctrlMispredict_i;
  // A mispredict makes any same-cycle allocation younger than the squash point.
  assign alloc_fire  = cpAlloc_i && !stall_i && !cpFull_o && !mispredict;
  assign retire_fire = valid[retire_ptr] && done[retire_ptr]
                       && !(mispredict && (ctrlCpId_i == retire_ptr));
  assign retire_next = retire_ptr + N_CP_LOG'(retire_fire);
  assign ctrl_age    = ctrlCpId_i - retire_ptr;

  always_comb begin
    squash  = '0;
    age     = '0;
    valid_n = valid;
    done_n  = done;
    // Age is measured from the oldest entry so a full ring still orders correctly.
    for (int i = 0; i < N_CP; i++) begin
      age       = N_CP_LOG'(i) - retire_ptr;
      squash[i] = mispredict && (age >= ctrl_age);
    end
    if (correct) done_n[ctrlCpId_i] = 1'b1;
    if (alloc_fire) begin
      valid_n[alloc_ptr] = 1'b1;
      done_n[alloc_ptr]  = 1'b0;
    end
    if (retire_fire) begin
      valid_n[retire_ptr] = 1'b0;
      done_n[retire_ptr]  = 1'b0;
    end
    valid_n = valid_n & ~squash;
    done_n  = done_n & ~squash;
  end

  always_ff @(posedge clk) begin
    if (reset || recoverFlag_i) begin
      valid      <= '0;
      done       <= '0;
      alloc_ptr  <= '0;
      retire_ptr <= '0;
      count      <= '0;
      verified_q <= 1'b0;
      recover_q  <= 1'b0;
      head_cp_q  <= '0;
    end else begin
      verified_q <= correct || mispredict;
      recover_q  <= mispredict;
      head_cp_q  <= mispredict ? head[ctrlCpId_i] : '0;
      if (alloc_fire) head[alloc_ptr] <= freeListHead_i;
      valid      <= valid_n;
      done       <= done_n;
      retire_ptr <= retire_next;
      if (mispredict) begin
        alloc_ptr <= ctrlCpId_i;
        count     <= {1'b0, N_CP_LOG'(ctrlCpId_i - retire_next)};
      end else begin
        alloc_ptr <= alloc_ptr + N_CP_LOG'(alloc_fire);
        count     <= count + (N_CP_LOG+1)'(alloc_fire) - (N_CP_LOG+1)'(retire_fire);
      end
    end
  end

endmodule

// File: tb/tb_freelist_checkpoint_ctrl.sv
// tb/tb_freelist_checkpoint_ctrl.sv - scoreboard bench for freelist_checkpoint_ctrl
// Stimulus queues expected resolve pulses; a monitor pops them when the DUT pulses.
module tb_freelist_checkpoint_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall_i = 1'b0, recoverFlag_i = 1'b0, cpAlloc_i = 1'b0;
  logic [4:0] freeListHead_i = '0;
  logic [1:0] cpId_o;
  logic       cpFull_o;
  logic       ctrlValid_i = 1'b0;
  logic [1:0] ctrlCpId_i = '0;
  logic       ctrlMispredict_i = 1'b0;
  logic       ctrlVerified_o, flagRecoverEX_o;
  logic [4:0] freeListHeadCp_o;
  logic [2:0] cpCount_o;

  freelist_checkpoint_ctrl #(.N_CP(4), .N_CP_LOG(2), .FL_LOG(5)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .recoverFlag_i(recoverFlag_i),
    .cpAlloc_i(cpAlloc_i), .freeListHead_i(freeListHead_i), .cpId_o(cpId_o),
    .cpFull_o(cpFull_o), .ctrlValid_i(ctrlValid_i), .ctrlCpId_i(ctrlCpId_i),
    .ctrlMispredict_i(ctrlMispredict_i), .ctrlVerified_o(ctrlVerified_o),
    .flagRecoverEX_o(flagRecoverEX_o), .freeListHeadCp_o(freeListHeadCp_o),
    .cpCount_o(cpCount_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       f;
    logic [4:0] h;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_pulse(input logic f, input logic [4:0] h);
    exp_t e;
    e.v = 1'b1;
    e.f = f;
    e.h = h;
    sb.push_back(e);
  endtask

  // One clock of stimulus; inputs return to idle afterwards.
  task automatic step(input logic alloc, input logic [4:0] hd, input logic stall,
                      input logic cv, input logic [1:0] cid, input logic mis,
                      input logic rf);
    cpAlloc_i = alloc; freeListHead_i = hd; stall_i = stall;
    ctrlValid_i = cv; ctrlCpId_i = cid; ctrlMispredict_i = mis; recoverFlag_i = rf;
    @(posedge clk); #1;
    cpAlloc_i = 1'b0; stall_i = 1'b0; ctrlValid_i = 1'b0;
    ctrlMispredict_i = 1'b0; recoverFlag_i = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic alloc(input logic [4:0] hd);
    step(1'b1, hd, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic [1:0] cid, input logic mis);
    step(1'b0, 5'd0, 1'b0, 1'b1, cid, mis, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  always @(posedge clk) begin
    #2;
    if (ctrlVerified_o === 1'b1 || flagRecoverEX_o === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got verified=%0b recover=%0b expected no pulse",
                 ctrlVerified_o, flagRecoverEX_o);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_verified", 32'(ctrlVerified_o), 32'(mon_e.v));
        check("pulse_recover", 32'(flagRecoverEX_o), 32'(mon_e.f));
        if (mon_e.f) check("restored_head", 32'(freeListHeadCp_o), 32'(mon_e.h));
      end
    end
  end

  initial begin
    do_reset();
    check("reset_count", 32'(cpCount_o), 0);
    check("reset_full", 32'(cpFull_o), 0);
    check("reset_id", 32'(cpId_o), 0);
    check("reset_verified", 32'(ctrlVerified_o), 0);
    check("reset_recover", 32'(flagRecoverEX_o), 0);

    // Fill: ids granted in order, stalled alloc ignored
    check("fill_id0", 32'(cpId_o), 0); alloc(5'd3);
    step(1'b1, 5'd30, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("stall_count", 32'(cpCount_o), 1);
    check("fill_id1", 32'(cpId_o), 1); alloc(5'd7);
    check("fill_id2", 32'(cpId_o), 2); alloc(5'd11);
    check("fill_id3", 32'(cpId_o), 3); alloc(5'd15);
    check("full_flag", 32'(cpFull_o), 1);
    check("full_count", 32'(cpCount_o), 4);
    alloc(5'd20);
    check("fifth_alloc_count", 32'(cpCount_o), 4);
    check("fifth_alloc_id", 32'(cpId_o), 0);

    // In-order release of id 0
    expect_pulse(1'b0, 5'd0); resolve(2'd0, 1'b0);
    check("release_count_same", 32'(cpCount_o), 4);
    idle();
    check("release_count", 32'(cpCount_o), 3);
    check("release_full", 32'(cpFull_o), 0);

    // Out-of-order release: 2 then 1
    expect_pulse(1'b0, 5'd0); resolve(2'd2, 1'b0);
    idle();
    check("ooo_no_retire", 32'(cpCount_o), 3);
    expect_pulse(1'b0, 5'd0); resolve(2'd1, 1'b0);
    check("ooo_before_retire", 32'(cpCount_o), 3);
    idle();
    check("ooo_retire1", 32'(cpCount_o), 2);
    idle();
    check("ooo_retire2", 32'(cpCount_o), 1);
    idle();
    check("ooo_hold", 32'(cpCount_o), 1);

    // Mispredict mid-list, then a dropped resolve to a squashed id
    do_reset();
    alloc(5'd3); alloc(5'd7); alloc(5'd11); alloc(5'd15);
    expect_pulse(1'b1, 5'd7); resolve(2'd1, 1'b1);
    check("mis_count", 32'(cpCount_o), 1);
    check("mis_next_id", 32'(cpId_o), 1);
    resolve(2'd3, 1'b1);
    check("squashed_resolve_count", 32'(cpCount_o), 1);
    alloc(5'd9);
    check("mis_realloc_count", 32'(cpCount_o), 2);
    check("mis_realloc_id", 32'(cpId_o), 2);
    idle();

    // Wrap, then mispredict the oldest in its retire cycle
    do_reset();
    alloc(5'd1); alloc(5'd2); alloc(5'd3); alloc(5'd4);
    expect_pulse(1'b0, 5'd0); resolve(2'd0, 1'b0);
    expect_pulse(1'b0, 5'd0); resolve(2'd1, 1'b0);
    check("wrap_count_a", 32'(cpCount_o), 3);
    expect_pulse(1'b0, 5'd0);
    step(1'b1, 5'd5, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    check("wrap_id", 32'(cpId_o), 1);
    check("wrap_count_b", 32'(cpCount_o), 3);
    expect_pulse(1'b0, 5'd0); resolve(2'd3, 1'b0);
    check("wrap_count_c", 32'(cpCount_o), 2);
    expect_pulse(1'b1, 5'd4);
    step(1'b1, 5'd6, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
    check("squash_all_count", 32'(cpCount_o), 0);
    check("squash_all_id", 32'(cpId_o), 3);
    check("squash_all_full", 32'(cpFull_o), 0);
    idle();

    // Flush with a simultaneous mispredict
    do_reset();
    alloc(5'd10); alloc(5'd11); alloc(5'd12);
    check("flush_pre_count", 32'(cpCount_o), 3);
    step(1'b0, 5'd0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
    check("flush_count", 32'(cpCount_o), 0);
    check("flush_id", 32'(cpId_o), 0);
    check("flush_verified", 32'(ctrlVerified_o), 0);
    check("flush_recover", 32'(flagRecoverEX_o), 0);
    idle(); idle();

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
